// File: rtl/cpu_axi_pkg.sv
// Shared AXI/fetch-bridge definitions: bridge FSM states, AXI encodings and
// the RRESP error qualifier used by the uncached instruction bridge.
package cpu_axi_pkg;

  // Bridge FSM: wait for request, address phase, data phase, hold word for fetch
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    AR   = 2'b01,
    R    = 2'b10,
    HOLD = 2'b11
  } bridge_state_e;

  localparam logic [2:0] AXSIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [7:0] AXLEN_SINGLE = 8'd0;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  // RRESP[1] separates SLVERR/DECERR from OKAY/EXOKAY
  localparam logic [1:0] RESP_ERR_MASK = 2'b10;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp & RESP_ERR_MASK) != (RESP_OKAY & RESP_ERR_MASK);
  endfunction

endpackage

// File: rtl/inst_uncached_bridge.sv
// Uncached instruction fetch bridge: turns a held fetch request into a single
// beat AXI read and holds the returned word until the fetch stage takes it.
// Flushes never abort an AXI handshake; in-flight beats are drained and dropped.
// Optional: INST_BRIDGE_ADDR_CHECK_EN drops a held word when the fetch PC
// changes without a flush.
module inst_uncached_bridge
  import cpu_axi_pkg::*;
#(
  parameter int                   ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0]  AR_ID    = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  input  logic [31:0]         req_addr,
  input  logic                req_flush,
  input  logic                resp_ready,
  output logic                resp_valid,
  output logic [31:0]         resp_data,
  output logic                resp_err,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  bridge_state_e state_q, state_d;
  logic [31:0]   araddr_q, araddr_d;
  logic          discard_q, discard_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic          resp_err_q, resp_err_d;
  logic          addr_mismatch;

  // Only one read is ever outstanding, so RID/RLAST carry no information
  logic unused_bits;
  assign unused_bits = ^{rid, rlast, req_addr[1:0]};

`ifdef INST_BRIDGE_ADDR_CHECK_EN
  assign addr_mismatch = (state_q == HOLD) && (req_addr[31:2] != araddr_q[31:2]);
`else
  assign addr_mismatch = 1'b0;
`endif

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      araddr_q    <= '0;
      discard_q   <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      discard_q   <= discard_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Next-state logic: request capture, AR/R handshakes, discard tracking
  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    discard_d   = discard_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !req_flush) begin
          araddr_d = {req_addr[31:2], 2'b00};
          state_d  = AR;
        end
      end
      AR: begin
        // arvalid must stay up once raised; a flush only marks the beat for discard
        if (req_flush) discard_d = 1'b1;
        if (arready)   state_d   = R;
      end
      R: begin
        if (rvalid) begin
          if (discard_q || req_flush) begin
            discard_d = 1'b0;
            state_d   = IDLE;
          end else begin
            resp_data_d = rdata;
            resp_err_d  = resp_is_err(rresp);
            state_d     = HOLD;
          end
        end else if (req_flush) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (resp_ready || req_flush || addr_mismatch) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign arvalid    = (state_q == AR);
  assign rready     = (state_q == R);
  assign resp_valid = (state_q == HOLD) && !addr_mismatch;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign araddr     = araddr_q;
  assign arid       = AR_ID;
  assign arlen      = AXLEN_SINGLE;
  assign arsize     = AXSIZE_WORD;
  assign arburst    = BURST_INCR;

endmodule
